// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALUOp codes,
// opcode/funct values, datapath mux selects and small decode helpers.
// Pure declarations; no logic, no latency, no flow control.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  // ALUOp codes, zero-extended to ALUOP_W at the controller output
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_LU    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_ADDU  = 3'd6;
  localparam logic [2:0] ALU_SLTU  = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // ALUSrcA / ALUSrcB
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_RS    = 2'b01;
  localparam logic [1:0] SA_SHAMT = 2'b10;
  localparam logic [1:0] SB_RT    = 2'b00;
  localparam logic [1:0] SB_FOUR  = 2'b01;
  localparam logic [1:0] SB_IMM   = 2'b10;
  localparam logic [1:0] SB_IMMSH = 2'b11;
  // PCSource / RegDst / MemtoReg
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;
  localparam logic [1:0] RD_RT      = 2'b00;
  localparam logic [1:0] RD_RD      = 2'b01;
  localparam logic [1:0] RD_RA      = 2'b10;
  localparam logic [1:0] MTR_MEM    = 2'b00;
  localparam logic [1:0] MTR_ALU    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  function automatic logic is_ialu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
           (op == OP_SLTI) || (op == OP_SLTIU) || (op == OP_LUI);
  endfunction

  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

  function automatic logic funct_ok(input logic [5:0] fn);
    return is_shift(fn) || (fn == FN_JR) || (fn == FN_JALR) ||
           ((fn >= 6'h20) && (fn <= 6'h2b));
  endfunction

  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE) return funct_ok(fn);
    return is_ialu(op) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_stall_wdog.sv
// Memory-stall watchdog: counts consecutive stall cycles, sets a sticky flag.
// Latency: flag registers one edge after the count reaches WAIT_LIMIT.
// Backpressure: none; purely observational, the FSM keeps waiting.
// Ports: clk, reset (sync, active-high), i_stall (IF/MEM waiting on memory),
//        o_timeout (sticky until reset; constant 0 when WAIT_LIMIT == 0).
module mc_stall_wdog #(
  parameter int WAIT_LIMIT = 0,
  parameter int WCNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_stall,
  output logic o_timeout
);

  localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_LIMIT);

  logic [WCNT_W-1:0] r_cnt;
  logic              r_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!i_stall)
        r_cnt <= '0;
      else if (r_cnt != '1)   // saturate instead of wrapping back to 0
        r_cnt <= r_cnt + 1'b1;
      if ((WAIT_LIMIT != 0) && (r_cnt == LIMIT))
        r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Five-state multi-cycle MIPS controller (IF/ID/EX/MEM/WB) with memory stalls.
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs are
// combinational from State/OpCode/Funct/MemReady. Backpressure: MemReady=0 holds IF/MEM.
// Ports: clk, reset (sync active-high, forces all outputs 0), OpCode/Funct from IR,
// MemReady handshake; datapath enables, mux selects, ALUOp, State, MemTimeout, Illegal.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions go ID -> TRAP(5) -> IF.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int WAIT_LIMIT = 0,
  parameter int WCNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         State,
  output logic               MemTimeout,
  output logic               Illegal
);

  state_t     r_state, w_next;
  logic       w_pcw, w_pcwc, w_bne, w_iord, w_mr, w_mw, w_irw, w_rw, w_ext, w_lui;
  logic [1:0] w_mtr, w_rd, w_sa, w_sb, w_pcs;
  logic [2:0] w_aluop;
  logic       w_stall, w_timeout;
`ifdef ILLEGAL_TRAP_EN
  logic       w_illegal;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_IF;
    w_pcw = 1'b0; w_pcwc = 1'b0; w_bne = 1'b0; w_iord = 1'b0; w_mr = 1'b0;
    w_mw = 1'b0; w_irw = 1'b0; w_rw = 1'b0; w_ext = 1'b0; w_lui = 1'b0;
    w_mtr = 2'b00; w_rd = 2'b00; w_sa = 2'b00; w_sb = 2'b00; w_pcs = 2'b00;
    w_aluop = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
    w_illegal = 1'b0;
`endif
    case (r_state)
      S_IF: begin
        w_mr = 1'b1;
        if (MemReady) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_sb   = SB_FOUR;
          w_next = S_ID;
        end
      end
      S_ID: begin
        // precompute branch target PC + (sext(imm) << 2)
        w_sb   = SB_IMMSH;
        w_ext  = 1'b1;
        w_next = S_EX;
`ifdef ILLEGAL_TRAP_EN
        if (!instr_legal(OpCode, Funct)) w_next = S_TRAP;
`endif
      end
      S_EX: begin
        if (OpCode == OP_RTYPE) begin
          // an unknown funct is a no-write NOP straight back to IF
          if (funct_ok(Funct)) begin
            w_sa    = is_shift(Funct) ? SA_SHAMT : SA_RS;
            w_aluop = ALU_FUNCT;
            if (Funct == FN_JR || Funct == FN_JALR) begin
              w_pcw = 1'b1;
              w_pcs = PCS_ALU;
              if (Funct == FN_JALR) begin
                w_rw  = 1'b1;
                w_rd  = RD_RD;
                w_mtr = MTR_PC;
              end
            end else begin
              w_next = S_WB;
            end
          end
        end else if (is_ialu(OpCode)) begin
          w_sa   = SA_RS;
          w_sb   = SB_IMM;
          w_ext  = (OpCode != OP_ANDI);
          w_lui  = (OpCode == OP_LUI);
          w_next = S_WB;
          case (OpCode)
            OP_ADDI:  w_aluop = ALU_ADD;
            OP_ADDIU: w_aluop = ALU_ADDU;
            OP_ANDI:  w_aluop = ALU_AND;
            OP_SLTI:  w_aluop = ALU_SLT;
            OP_SLTIU: w_aluop = ALU_SLTU;
            default:  w_aluop = ALU_LU;
          endcase
        end else if (OpCode == OP_LW || OpCode == OP_SW) begin
          w_sa   = SA_RS;
          w_sb   = SB_IMM;
          w_ext  = 1'b1;
          w_next = S_MEM;
        end else if (OpCode == OP_BEQ || OpCode == OP_BNE) begin
          w_pcwc  = 1'b1;
          w_sa    = SA_RS;
          w_sb    = SB_RT;
          w_pcs   = PCS_ALUOUT;
          w_aluop = ALU_SUB;
          w_bne   = (OpCode == OP_BNE);
        end else if (OpCode == OP_J || OpCode == OP_JAL) begin
          w_pcw = 1'b1;
          w_pcs = PCS_JUMP;
          if (OpCode == OP_JAL) begin
            w_rw  = 1'b1;
            w_rd  = RD_RA;
            w_mtr = MTR_PC;
          end
        end
      end
      S_MEM: begin
        w_iord = 1'b1;
        if (OpCode == OP_LW) begin
          w_mr   = 1'b1;
          w_next = MemReady ? S_WB : S_MEM;
        end else if (OpCode == OP_SW) begin
          // MemWrite stays high through stalls; memory commits on the ready cycle
          w_mw   = 1'b1;
          w_next = MemReady ? S_IF : S_MEM;
        end
      end
      S_WB: begin
        w_rw = 1'b1;
        if (OpCode == OP_RTYPE) begin
          w_rd  = RD_RD;
          w_mtr = MTR_ALU;
        end else begin
          w_rd  = RD_RT;
          w_mtr = (OpCode == OP_LW) ? MTR_MEM : MTR_ALU;
        end
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_illegal = 1'b1;
        w_pcw     = 1'b1;
        w_pcs     = PCS_EXC;
      end
`endif
      default: ;
    endcase
  end

  assign w_stall = ((r_state == S_IF) || (r_state == S_MEM)) && !MemReady;

  mc_stall_wdog #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .WCNT_W     (WCNT_W)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_stall   (w_stall),
    .o_timeout (w_timeout)
  );

  // reset forces every output low so an abandoned instruction writes nothing
  assign PCWrite     = !reset && w_pcw;
  assign PCWriteCond = !reset && w_pcwc;
  assign BranchNe    = !reset && w_bne;
  assign IorD        = !reset && w_iord;
  assign MemRead     = !reset && w_mr;
  assign MemWrite    = !reset && w_mw;
  assign IRWrite     = !reset && w_irw;
  assign RegWrite    = !reset && w_rw;
  assign ExtOp       = !reset && w_ext;
  assign LuiOp       = !reset && w_lui;
  assign MemtoReg    = reset ? 2'b00 : w_mtr;
  assign RegDst      = reset ? 2'b00 : w_rd;
  assign ALUSrcA     = reset ? 2'b00 : w_sa;
  assign ALUSrcB     = reset ? 2'b00 : w_sb;
  assign PCSource    = reset ? 2'b00 : w_pcs;
  assign ALUOp       = reset ? '0 : ALUOP_W'(w_aluop);
  assign State       = reset ? 3'd0 : r_state;
  assign MemTimeout  = !reset && w_timeout;
`ifdef ILLEGAL_TRAP_EN
  assign Illegal     = !reset && w_illegal;
`else
  assign Illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed test-plan instructions, then random
// instruction streams with random memory waits, checked against an instruction-level model.
// Handles both builds of ILLEGAL_TRAP_EN.
module tb_mc_ctrl_fsm;

  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic       RegWrite, ExtOp, LuiOp, MemTimeout, Illegal;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic [2:0] State;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALUOP_W(4), .WAIT_LIMIT(WL), .WCNT_W(8)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ExtOp(ExtOp), .LuiOp(LuiOp), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .State(State), .MemTimeout(MemTimeout), .Illegal(Illegal)
  );

  typedef struct packed {
    logic       ill, pcw, pcwc, bne, iord, mr, mw, irw, rw, ext, lui;
    logic [1:0] mtr, rd, sa, sb, pcs;
    logic [3:0] alu;
  } ctl_t;

  ctl_t obs;
  assign obs = {Illegal, PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
                IRWrite, RegWrite, ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB,
                PCSource, ALUOp};

  // instruction classes
  localparam int C_BAD = 0, C_RALU = 1, C_SHIFT = 2, C_JR = 3, C_JALR = 4, C_IALU = 5,
                 C_LW = 6, C_SW = 7, C_BR = 8, C_J = 9, C_JAL = 10;

  int total = 0;
  int bad   = 0;
  int run   = 0;     // consecutive memory-wait cycles before the current cycle
  bit tflag = 1'b0;  // expected MemTimeout

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return C_SHIFT;
        if (fn == 6'h08) return C_JR;
        if (fn == 6'h09) return C_JALR;
        if (fn >= 6'h20 && fn <= 6'h2b) return C_RALU;
        return C_BAD;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: return C_IALU;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_BAD;
    endcase
  endfunction

  function automatic ctl_t ex_ctl(input logic [5:0] op, input int cls);
    ctl_t c = '0;
    case (cls)
      C_SHIFT: begin c.sa = 2; c.alu = 2; end
      C_RALU:  begin c.sa = 1; c.alu = 2; end
      C_JR:    begin c.sa = 1; c.alu = 2; c.pcw = 1; end
      C_JALR:  begin c.sa = 1; c.alu = 2; c.pcw = 1; c.rw = 1; c.rd = 1; c.mtr = 2; end
      C_IALU: begin
        c.sa = 1; c.sb = 2; c.ext = (op != 6'h0c); c.lui = (op == 6'h0f);
        case (op)
          6'h08: c.alu = 0;
          6'h09: c.alu = 6;
          6'h0c: c.alu = 3;
          6'h0a: c.alu = 5;
          6'h0b: c.alu = 7;
          default: c.alu = 4;
        endcase
      end
      C_LW, C_SW: begin c.sa = 1; c.sb = 2; c.ext = 1; end
      C_BR: begin c.pcwc = 1; c.sa = 1; c.pcs = 1; c.alu = 1; c.bne = (op == 6'h05); end
      C_J:   begin c.pcw = 1; c.pcs = 2; end
      C_JAL: begin c.pcw = 1; c.pcs = 2; c.rw = 1; c.rd = 2; c.mtr = 2; end
      default: ;
    endcase
    return c;
  endfunction

  // one clock: drive MemReady, check at negedge, then step the watchdog model
  task automatic cyc(input string tag, input logic mr, input int est, input ctl_t e);
    bit stall;
    MemReady = mr;
    @(negedge clk);
    check({tag, "/state"}, 32'(State), 32'(est));
    check({tag, "/ctl"}, 32'(obs), 32'(e));
    check({tag, "/tmo"}, 32'(MemTimeout), 32'(tflag));
    stall = ((est == 0) || (est == 3)) && !mr;
    if (run == WL) tflag = 1'b1;
    run = stall ? run + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    check("rst/state", 32'(State), 32'd0);
    check("rst/ctl", 32'(obs), 32'd0);
    check("rst/tmo", 32'(MemTimeout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 0;
    tflag = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int nif, input int nmem);
    ctl_t  c;
    int    cls;
    string t;
    cls    = classify(op, fn);
    t      = $sformatf("op%h_fn%h", op, fn);
    OpCode = op;
    Funct  = fn;
    c = '0; c.mr = 1;
    for (int k = 0; k < nif; k++) cyc({t, "/IFwait"}, 1'b0, 0, c);
    c.irw = 1; c.pcw = 1; c.sb = 1;
    cyc({t, "/IF"}, 1'b1, 0, c);
    c = '0; c.sb = 3; c.ext = 1;
    cyc({t, "/ID"}, 1'($urandom_range(0, 1)), 1, c);
`ifdef ILLEGAL_TRAP_EN
    if (cls == C_BAD) begin
      c = '0; c.ill = 1; c.pcw = 1; c.pcs = 3;
      cyc({t, "/TRAP"}, 1'($urandom_range(0, 1)), 5, c);
      return;
    end
`endif
    cyc({t, "/EX"}, 1'($urandom_range(0, 1)), 2, ex_ctl(op, cls));
    if (cls == C_LW || cls == C_SW) begin
      c = '0; c.iord = 1;
      if (cls == C_LW) c.mr = 1; else c.mw = 1;
      for (int k = 0; k < nmem; k++) cyc({t, "/MEMwait"}, 1'b0, 3, c);
      cyc({t, "/MEM"}, 1'b1, 3, c);
    end
    if (cls == C_RALU || cls == C_SHIFT || cls == C_IALU || cls == C_LW) begin
      c = '0; c.rw = 1;
      c.rd  = (cls == C_RALU || cls == C_SHIFT) ? 2'd1 : 2'd0;
      c.mtr = (cls == C_LW) ? 2'd0 : 2'd1;
      cyc({t, "/WB"}, 1'($urandom_range(0, 1)), 4, c);
    end
  endtask

  logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b, 6'h0f,
                           6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f, 6'h01, 6'h1c};
  logic [5:0] fns [19] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
                           6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h01, 6'h3f, 6'h0c,
                           6'h28};

  initial begin
    ctl_t c;
    reset    = 1'b1;
    OpCode   = 6'h08;
    Funct    = 6'h00;
    MemReady = 1'b1;
    do_reset();

    // directed test-plan instructions
    run_instr(6'h08, 6'h00, 0, 0);   // addi, no stalls
    run_instr(6'h23, 6'h00, 0, 3);   // lw, 3 MEM waits
    run_instr(6'h2b, 6'h00, 2, 0);   // sw, 2 IF waits
    run_instr(6'h05, 6'h00, 0, 0);   // bne
    run_instr(6'h04, 6'h00, 1, 0);   // beq
    run_instr(6'h3f, 6'h00, 0, 0);   // illegal opcode
    run_instr(6'h00, 6'h09, 0, 0);   // jalr
    run_instr(6'h03, 6'h00, 0, 0);   // jal

    // random instruction stream; waits stay short of the watchdog limit
    for (int n = 0; n < 60; n++)
      run_instr(ops[$urandom_range(0, 17)], fns[$urandom_range(0, 18)],
                $urandom_range(0, 3), $urandom_range(0, 3));

    // reset while a load is stalled in MEM
    OpCode = 6'h23;
    Funct  = 6'h00;
    c = '0; c.mr = 1; c.irw = 1; c.pcw = 1; c.sb = 1;
    cyc("rstmem/IF", 1'b1, 0, c);
    c = '0; c.sb = 3; c.ext = 1;
    cyc("rstmem/ID", 1'b1, 1, c);
    cyc("rstmem/EX", 1'b1, 2, ex_ctl(6'h23, C_LW));
    c = '0; c.iord = 1; c.mr = 1;
    cyc("rstmem/MEMwait", 1'b0, 3, c);
    do_reset();
    run_instr(6'h0f, 6'h00, 0, 0);   // lui after reset starts cleanly in IF

    // watchdog: 10 IF wait cycles trip the sticky flag, only reset clears it
    run_instr(6'h08, 6'h00, 10, 0);
    check("wdog/sticky_model", 32'(tflag), 32'd1);
    run_instr(6'h00, 6'h20, 0, 0);
    do_reset();
    run_instr(6'h0c, 6'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
